// File: rtl/temp_avg_ram_ctl.sv
// temp_avg_ram_ctl
// Read-side sequencer for the temperature FIFO. It pops four temperature
// bytes (one packet) and accumulates them. It then writes the truncated
// average to the display RAM. Successive packets go to successive RAM
// locations, counting down from RAM_TOP and wrapping back to RAM_TOP after
// address zero.
module temp_avg_ram_ctl #(
  parameter int                 DATA_W  = 8,
  parameter int                 ADDR_W  = 11,
  parameter logic [ADDR_W-1:0]  RAM_TOP = 11'h7FF
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ACC  = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  state_t              state_r;
  logic [DATA_W+1:0]   acc_r;
  logic [1:0]          byte_cnt_r;
  logic [DATA_W+1:0]   sum_s;
  logic [ADDR_W-1:0]   addr_next_s;

  // Running sum including the byte currently presented by the FIFO; four
  // full-scale bytes still fit in DATA_W+2 bits, so this never overflows.
  always_comb begin
    sum_s = acc_r + {2'b00, fifo_data};
  end

  // Next write address: count down, and restart at RAM_TOP after address zero.
  always_comb begin
    addr_next_s = ram_addr - {{(ADDR_W-1){1'b0}}, 1'b1};
    if (ram_addr == {ADDR_W{1'b0}}) begin
      addr_next_s = RAM_TOP;
    end else begin
      addr_next_s = ram_addr - {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Packet sequencer. The strobes are registered together with the state,
  // so fifo_rd is high exactly in RD and ram_wr exactly in WR.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      acc_r      <= '0;
      byte_cnt_r <= 2'd0;
      fifo_rd    <= 1'b0;
      ram_wr     <= 1'b0;
      ram_data   <= '0;
      ram_addr   <= RAM_TOP;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ram_wr <= 1'b0;
          if (!fifo_empty) begin
            state_r <= ST_RD;
            fifo_rd <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            fifo_rd <= 1'b0;
          end
        end
        ST_RD: begin
          // The popped byte appears on fifo_data during ACC.
          state_r <= ST_ACC;
          fifo_rd <= 1'b0;
          ram_wr  <= 1'b0;
        end
        ST_ACC: begin
          acc_r      <= sum_s;
          byte_cnt_r <= byte_cnt_r + 2'd1;
          fifo_rd    <= 1'b0;
          busy       <= 1'b1;
          if (byte_cnt_r == 2'd3) begin
            // Fourth byte: floor(sum/4) is the sum with the low two bits dropped.
            state_r  <= ST_WR;
            ram_wr   <= 1'b1;
            ram_data <= sum_s[DATA_W+1:2];
          end else begin
            state_r <= ST_IDLE;
            ram_wr  <= 1'b0;
          end
        end
        ST_WR: begin
          state_r    <= ST_IDLE;
          acc_r      <= '0;
          byte_cnt_r <= 2'd0;
          fifo_rd    <= 1'b0;
          ram_wr     <= 1'b0;
          ram_addr   <= addr_next_s;
          busy       <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          fifo_rd <= 1'b0;
          ram_wr  <= 1'b0;
          busy    <= (byte_cnt_r != 2'd0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_avg_ram_ctl.sv
// tb_temp_avg_ram_ctl
// Bench for temp_avg_ram_ctl. A queue models the FIFO, and expected RAM
// writes are queued as {addr, data} when a packet is driven. A negedge
// monitor pops and compares one expectation per ram_wr pulse.
module tb_temp_avg_ram_ctl;

  logic        clk_50;
  logic        reset_n;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [7:0]  fifo_data;
  logic        ram_wr;
  logic [10:0] ram_addr;
  logic [7:0]  ram_data;
  logic        busy;

  logic [7:0]  fifo_q[$];
  logic [18:0] sb_q[$];
  logic [10:0] exp_addr;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          rd_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [7:0]  pend_byte = 8'h00;
  logic        measure = 1'b0;
  int          t_first = -1;
  int          t_wr    = -1;

  temp_avg_ram_ctl dut (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .busy       (busy)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // FIFO model and output monitor, all working on the falling edge.
  always @(negedge clk_50) begin
    cyc++;
    // The popped byte is valid only in the cycle after the fifo_rd cycle.
    if (rd_pend) fifo_data = pend_byte;
    else         fifo_data = 8'hC3;
    rd_pend = 1'b0;
    if (reset_n && fifo_rd) begin
      check_val("rd_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
      if (fifo_q.size() != 0) pend_byte = fifo_q.pop_front();
      rd_pend = 1'b1;
      rd_cnt++;
      if (measure && t_first < 0) t_first = cyc;
    end
    if (reset_n && ram_wr) begin
      if (measure) t_wr = cyc;
      check_val("busy_in_wr", {31'd0, busy}, 32'd1);
      check_val("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        logic [18:0] e;
        e = sb_q.pop_front();
        check_val("wr_addr", {21'd0, ram_addr}, {21'd0, e[18:8]});
        check_val("wr_data", {24'd0, ram_data}, {24'd0, e[7:0]});
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic push_exp(input logic [7:0] avg);
    sb_q.push_back({exp_addr, avg});
    exp_addr = (exp_addr == 11'd0) ? 11'h7FF : exp_addr - 11'd1;
  endtask

  task automatic send_packet(input logic [7:0] b0, b1, b2, b3);
    logic [9:0] s;
    s = {2'b00, b0} + {2'b00, b1} + {2'b00, b2} + {2'b00, b3};
    push_exp(s[9:2]);
    fifo_q.push_back(b0);
    fifo_q.push_back(b1);
    fifo_q.push_back(b2);
    fifo_q.push_back(b3);
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk_50);
      #1;
      if (sb_q.size() == 0 && fifo_q.size() == 0 && !busy && !rd_pend) done = 1'b1;
    end
    check_val(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset(input logic check_outputs);
    @(negedge clk_50);
    #2;
    reset_n = 1'b0;
    fifo_q.delete();
    rd_pend = 1'b0;
    exp_addr = 11'h7FF;
    #1;
    if (check_outputs) begin
      check_val("rst_fifo_rd",  {31'd0, fifo_rd},  32'd0);
      check_val("rst_ram_wr",   {31'd0, ram_wr},   32'd0);
      check_val("rst_ram_data", {24'd0, ram_data}, 32'd0);
      check_val("rst_busy",     {31'd0, busy},     32'd0);
      check_val("rst_ram_addr", {21'd0, ram_addr}, 32'h7FF);
    end
    repeat (3) @(negedge clk_50);
    #2;
    reset_n = 1'b1;
  endtask

  // Test sequence.
  initial begin
    reset_n    = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    exp_addr   = 11'h7FF;
    repeat (2) @(negedge clk_50);

    // Reset state.
    do_reset(1'b1);
    repeat (2) @(negedge clk_50);

    // Basic packet: 4 reads, one write, 13-cycle packet.
    begin
      int rd0;
      rd0 = rd_cnt;
      measure = 1'b1;
      t_first = -1;
      t_wr = -1;
      send_packet(8'h10, 8'h20, 8'h30, 8'h40);
      wait_done("pkt1_done", 60);
      measure = 1'b0;
      check_val("pkt1_rd_count", rd_cnt - rd0, 32'd4);
      check_val("pkt1_rd_to_wr", t_wr - t_first, 32'd11);
      check_val("pkt1_next_addr", {21'd0, ram_addr}, 32'h7FE);
    end

    // Near full-scale sum: truncation, no overflow.
    send_packet(8'hFF, 8'hFF, 8'hFF, 8'hFE);
    wait_done("pkt_max_done", 60);

    // Starvation mid-packet.
    begin
      fifo_q.push_back(8'h08);
      fifo_q.push_back(8'h0C);
      repeat (10) @(negedge clk_50);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_50);
        #1;
        check_val("starve_busy", {31'd0, busy}, 32'd1);
        check_val("starve_no_rd", {31'd0, fifo_rd}, 32'd0);
      end
      push_exp(8'h0E);
      fifo_q.push_back(8'h10);
      fifo_q.push_back(8'h14);
      wait_done("starve_done", 60);
    end

    // Full address sweep with wrap back to the top.
    do_reset(1'b0);
    for (int p = 0; p < 2049; p++) send_packet(8'h05, 8'h05, 8'h05, 8'h05);
    wait_done("sweep_done", 2049 * 13 + 200);
    check_val("sweep_next_addr", {21'd0, ram_addr}, 32'h7FE);

    // Reset in the middle of a packet discards the partial sum.
    begin
      int rd0;
      rd0 = rd_cnt;
      fifo_q.push_back(8'h77);
      fifo_q.push_back(8'h99);
      for (int i = 0; i < 40 && rd_cnt < rd0 + 2; i++) @(negedge clk_50);
      repeat (3) @(negedge clk_50);
      check_val("partial_busy", {31'd0, busy}, 32'd1);
      do_reset(1'b0);
      #1;
      check_val("partial_cleared_busy", {31'd0, busy}, 32'd0);
      send_packet(8'h04, 8'h04, 8'h08, 8'h08);
      wait_done("after_reset_done", 60);
    end

    repeat (5) @(negedge clk_50);
    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
